// File: rtl/adc_clkgen_sync.sv
// adc_clkgen_sync: counter-based SAR ADC clock generator (sample, comparator
// and SAR-logic clocks) with comparator handshake and stall timeout.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ena_in            continuous mode, back-to-back conversions
//   start_conv        single-shot start, rising-edge sensitive
//   comp_trig         async comparator-ready, 2-flop synchronized
//   sample_cfg        sample phase length in cycles (0 -> 1)
//   dig_cfg           clk_dig high length in cycles (0 -> 1)
//   clk_comp, clk_dig comparator / SAR clocks, registered, never overlapping
//   sample            sample phase active
//   busy              any state other than IDLE
//   conv_done         one-cycle end-of-conversion pulse
//   bit_idx           current bit, RESOLUTION-1 down to 0
//   timeout_err       sticky comparator-stall flag
//   overrun           sticky start-while-busy flag
module adc_clkgen_sync #(
    parameter int RESOLUTION     = 8,
    parameter int CNT_W          = 6,
    parameter int TIMEOUT_CYCLES = 63,
    parameter int IDX_W          = $clog2(RESOLUTION)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena_in,
    input  logic             start_conv,
    input  logic             comp_trig,
    input  logic [CNT_W-1:0] sample_cfg,
    input  logic [CNT_W-1:0] dig_cfg,
    output logic             clk_comp,
    output logic             clk_dig,
    output logic             sample,
    output logic             busy,
    output logic             conv_done,
    output logic [IDX_W-1:0] bit_idx,
    output logic             timeout_err,
    output logic             overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_COMP,
        S_DIG,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(RESOLUTION - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bit_q, bit_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;

    logic start_q;
    logic sync1_q, sync2_q, sync3_q;
    logic edge_q;

    logic clk_comp_q, clk_dig_q, sample_q, busy_q, done_q;

    logic             start_edge;
    logic             go_sample;
    logic [CNT_W-1:0] sample_len;
    logic [CNT_W-1:0] dig_len;

    assign start_edge = start_conv & ~start_q;
    assign sample_len = (sample_cfg == '0) ? CNT_ONE : sample_cfg;
    assign dig_len    = (dig_cfg == '0) ? CNT_ONE : dig_cfg;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        go_sample = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // a simultaneous edge and ena_in still yields one start
                if (start_edge || ena_in) begin
                    go_sample = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_COMP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_COMP: begin
                if (edge_q) begin
                    state_d = S_DIG;
                    cnt_d   = dig_len;
                end else if (cnt_q >= TO_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DIG: begin
                if (cnt_q <= CNT_ONE) begin
                    if (bit_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_COMP;
                        bit_d   = bit_q - IDX_W'(1);
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                if (ena_in) begin
                    go_sample = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_sample) begin
            state_d   = S_SAMPLE;
            cnt_d     = sample_len;
            bit_d     = IDX_TOP;
            timeout_d = 1'b0;
            overrun_d = 1'b0;
        end

        // set after the clear so an edge in DONE is never lost
        if (start_edge && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            start_q    <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            edge_q     <= 1'b0;
            clk_comp_q <= 1'b0;
            clk_dig_q  <= 1'b0;
            sample_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            start_q    <= start_conv;
            sync1_q    <= comp_trig;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            // a level already high on COMP entry produces no edge here
            edge_q     <= sync2_q & ~sync3_q;
            clk_comp_q <= (state_d == S_COMP);
            clk_dig_q  <= (state_d == S_DIG);
            sample_q   <= (state_d == S_SAMPLE);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign clk_comp    = clk_comp_q;
    assign clk_dig     = clk_dig_q;
    assign sample      = sample_q;
    assign busy        = busy_q;
    assign conv_done   = done_q;
    assign bit_idx     = bit_q;
    assign timeout_err = timeout_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/adc_clkgen_sync.md
Name: adc_clkgen_sync

Overview:
Synchronous, parametrised successor to the delay-line SAR ADC clock generator. It replaces the fixed delay-cell timing with cycle counters driven by the system clock. It detects a conversion start (a start_conv rising edge or a continuous-mode enable) and runs a sample phase. It then runs RESOLUTION comparator/digital clock cycles, handshaking on comp_trig, with a timeout on a stalled comparator. It sits between the digital SAR controller and the analog comparator and DAC.

Parameters:
RESOLUTION, 8, comparator cycles per conversion (2..16).
CNT_W, 6, width of the phase-length config inputs and the internal phase counter.
TIMEOUT_CYCLES, 63, maximum cycles in COMP waiting for comp_trig before abort (1..2^CNT_W-1).
IDX_W, $clog2(RESOLUTION), width of bit_idx.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous active-high reset.
ena_in  input  1  continuous mode: when high, conversions start back-to-back.
start_conv  input  1  single-shot start, synchronous to clk, rising-edge sensitive.
comp_trig  input  1  comparator-ready, asynchronous; passes through a 2-flop synchronizer.
sample_cfg  input  CNT_W  sample phase length in cycles (0 treated as 1).
dig_cfg  input  CNT_W  clk_dig high length in cycles (0 treated as 1).
clk_comp  output  1  comparator clock, registered.
clk_dig  output  1  SAR logic clock, registered.
sample  output  1  sample phase active, registered.
busy  output  1  high in any state other than IDLE.
conv_done  output  1  one-cycle pulse at the end of a conversion.
bit_idx  output  IDX_W  current bit, counts RESOLUTION-1 down to 0.
timeout_err  output  1  sticky; set on comparator timeout, cleared at the next conversion start.
overrun  output  1  sticky; set when a start_conv edge arrives while busy, cleared at the next conversion start.

Behaviour:
- Reset: state IDLE. All outputs 0, bit_idx 0. Synchronizer, edge registers and counters are cleared.
- Start edge: start_conv & ~start_q, where start_q is start_conv registered.
- comp_trig edge: rising edge of the synchronized signal, giving 3 cycles of latency from the pin.
- Start condition in IDLE: a start edge, or ena_in==1. On the next edge: state SAMPLE, sample=1, busy=1, bit_idx=RESOLUTION-1, timeout_err=0, overrun=0, counter loaded with max(sample_cfg,1).
- SAMPLE: sample=1 for exactly max(sample_cfg,1) cycles, then COMP.
- COMP: clk_comp=1 and the counter counts up from 0.
  - A comp_trig rising edge seen while in COMP moves to DIG on the next edge. A comp_trig already high on entry is ignored until it falls and rises again.
  - If the counter reaches TIMEOUT_CYCLES without an edge: set timeout_err and go to DONE. clk_comp drops on that transition.
- DIG: clk_comp=0 and clk_dig=1 for max(dig_cfg,1) cycles.
  - At exit, if bit_idx==0 go to DONE; otherwise decrement bit_idx and go to COMP.
  - clk_comp and clk_dig must never be high in the same cycle. The transitions in both directions are single-edge swaps.
- DONE: one cycle, conv_done=1, all clocks low.
  - Next state is SAMPLE if ena_in==1, else IDLE. Re-entering SAMPLE clears the sticky flags, as a fresh start does.
- overrun: a start edge in any state other than IDLE sets it, and the edge is otherwise ignored. A start edge in the DONE cycle also counts as overrun.
- Simultaneous start edge and ena_in in IDLE: exactly one conversion starts.
- rst mid-conversion: everything returns to reset values on the next edge. No conv_done pulse is generated.
- Config inputs are sampled at each counter load. A change mid-phase takes effect from the next phase.
- Nominal conversion length with no timeout, where D = max(dig_cfg,1) and W = cycles spent in COMP for each bit: 1 + max(sample_cfg,1) + sum over bits of (W + D) + 1 cycles from start edge to conv_done.

Test Plan:
- Reset: hold rst 3 cycles with start_conv=1 and ena_in=1 -> all outputs 0 throughout reset; the first conversion starts 1 cycle after rst falls.
- Single shot, RESOLUTION=8, sample_cfg=4, dig_cfg=2, comp_trig pulsed 2 cycles high each time clk_comp rises:
  - sample high for 4 cycles;
  - 8 clk_comp pulses each followed by a 2-cycle clk_dig pulse;
  - bit_idx runs 7..0;
  - one conv_done pulse; busy falls the cycle after conv_done;
  - clk_comp and clk_dig never overlap.
- Timeout: comp_trig held 0 -> clk_comp high for exactly 63 cycles, timeout_err=1, conv_done pulses, return to IDLE. The next start clears timeout_err.
- Continuous: ena_in=1 for 3 conversions -> conv_done is followed immediately by sample=1, with no IDLE cycle between conversions. Dropping ena_in during the third conversion leaves the machine in IDLE after that conv_done.
- Overrun and config edge cases: start_conv edge mid-COMP -> overrun=1 and no restart. Then sample_cfg=0 and dig_cfg=0 -> sample and clk_dig each last 1 cycle.
- Stuck comparator: comp_trig held 1 on entry to COMP -> no DIG transition until comp_trig toggles 0 then 1; clk_dig rises 3 cycles after the pin rise plus 1.
